stack_cache_line_xfer_ctrl: RTL and testbench

Sequences spill and fill transfers between one stack cache line and the backing memory port. On a spill it walks the line by entry index, reads each entry combinationally through the line's read port and issues write requests for dirty entries. On a fill it issues LINESIZE read requests and writes the in-order responses into the line through its write port. It sits between the stack pointer/window logic (requester) and the line array plus memory request arbiter.

---
 rtl/stack_cache_pkg.sv | 18 +
 rtl/stack_cache_fill_tracker.sv | 58 +++++
 rtl/stack_cache_line_xfer_ctrl.sv | 148 ++++++++++++++
 tb/tb_stack_cache_line_xfer_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_cache_pkg.sv
// Shared types and helpers for the stack cache line transfer controller.
//   xfer_state_t  : controller state (IDLE, SPILL, FILL, DONE)
//   alignLineBase : clears the entry-offset bits of a line base address
package stack_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

    // offsetBits is log2(entries per line); a one-entry line has no offset bits.
    function automatic logic [63:0] alignLineBase(input logic [63:0] base, input int offsetBits);
        return base & ~((64'd1 << offsetBits) - 64'd1);
    endfunction

endpackage

// File: rtl/stack_cache_fill_tracker.sv
// Tracks read requests issued and responses returned during a line fill.
// Ports:
//   clk, async_rst, clk_en : clock, async active-high reset, update enable
//   active                 : controller is in FILL; counters clear otherwise
//   issueFire              : a read request handshake happens this cycle
//   respValid              : raw memory response valid
//   issueIdx / respIdx     : next entry index to request / to write back
//   issueDone              : all LINESIZE reads have been issued
//   allReturned            : all LINESIZE responses have been written
//   respFire               : a response is accepted this cycle
module stack_cache_fill_tracker #(
    parameter int LINESIZE         = 8,
    parameter int LINEADDRBITWIDTH = (LINESIZE == 1) ? 1 : $clog2(LINESIZE)
) (
    input  logic                        clk,
    input  logic                        async_rst,
    input  logic                        clk_en,
    input  logic                        active,
    input  logic                        issueFire,
    input  logic                        respValid,
    output logic [LINEADDRBITWIDTH-1:0] issueIdx,
    output logic [LINEADDRBITWIDTH-1:0] respIdx,
    output logic                        issueDone,
    output logic                        allReturned,
    output logic                        respFire
);

    localparam int CW = LINEADDRBITWIDTH + 1;

    logic [CW-1:0] issueCnt;
    logic [CW-1:0] respCnt;

    assign issueIdx    = issueCnt[LINEADDRBITWIDTH-1:0];
    assign respIdx     = respCnt[LINEADDRBITWIDTH-1:0];
    assign issueDone   = (issueCnt == CW'(LINESIZE));
    assign allReturned = (respCnt == CW'(LINESIZE));
    // A response with nothing outstanding cannot belong to this fill; drop it.
    assign respFire    = clk_en && active && respValid && (respCnt != issueCnt);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            issueCnt <= '0;
            respCnt  <= '0;
        end else if (clk_en) begin
            if (!active) begin
                issueCnt <= '0;
                respCnt  <= '0;
            end else begin
                if (issueFire) issueCnt <= issueCnt + 1'b1;
                if (respFire)  respCnt  <= respCnt + 1'b1;
            end
        end
    end

    respWithoutRequest: assert property (@(posedge clk) disable iff (async_rst)
        (clk_en && active && respValid) |-> (respCnt != issueCnt));

endmodule

// File: rtl/stack_cache_line_xfer_ctrl.sv
// Spill/fill sequencer between one stack cache line and the memory port.
// Spill walks the line by index, writing entries out through the memory
// port; fill issues LINESIZE reads and writes the in-order responses back.
// Build option: STACK_CACHE_SPILL_SKIP_CLEAN_EN -- when defined, clean entries
// are skipped during spill; otherwise every entry is written (fixed latency).
// Ports:
//   clk, async_rst, clk_en          : clock, async active-high reset, enable
//   ReqReady/SpillReq/FillReq/LineBase : requester side
//   Busy, DonePulse                 : status
//   LineRead*/LineDataOut/LineIsDirty/LineCleanEn : line read/clean port
//   LineWrite*/LineDataIn           : line fill write port
//   MemReq*/MemResp*                : memory request/response port
module stack_cache_line_xfer_ctrl
    import stack_cache_pkg::*;
#(
    parameter int LINESIZE         = 8,
    parameter int DATABITWIDTH     = 16,
    parameter int ADDRBITWIDTH     = 16,
    parameter int LINEADDRBITWIDTH = (LINESIZE == 1) ? 1 : $clog2(LINESIZE)
) (
    input  logic                        clk,
    input  logic                        async_rst,
    input  logic                        clk_en,
    output logic                        ReqReady,
    input  logic                        SpillReq,
    input  logic                        FillReq,
    input  logic [ADDRBITWIDTH-1:0]     LineBase,
    output logic                        Busy,
    output logic                        DonePulse,
    output logic [LINEADDRBITWIDTH-1:0] LineReadAddr,
    output logic                        LineReadEn,
    input  logic [DATABITWIDTH-1:0]     LineDataOut,
    input  logic                        LineIsDirty,
    output logic                        LineCleanEn,
    output logic [LINEADDRBITWIDTH-1:0] LineWriteAddr,
    output logic                        LineWriteEn,
    output logic [DATABITWIDTH-1:0]     LineDataIn,
    output logic                        MemReqValid,
    input  logic                        MemReqReady,
    output logic                        MemReqWrite,
    output logic [ADDRBITWIDTH-1:0]     MemReqAddr,
    output logic [DATABITWIDTH-1:0]     MemReqData,
    input  logic                        MemRespValid,
    input  logic [DATABITWIDTH-1:0]     MemRespData
);

    xfer_state_t                 state;
    logic [LINEADDRBITWIDTH-1:0] spillIdx;
    logic                        fillPending;
    logic [ADDRBITWIDTH-1:0]     baseReg;
    logic [ADDRBITWIDTH-1:0]     alignedBase;

    logic inSpill, inFill, entryWrite, handshake, spillAdvance, issueFire;
    logic issueDone, allReturned, respFire;
    logic [LINEADDRBITWIDTH-1:0] issueIdx, respIdx;

`ifdef STACK_CACHE_SPILL_SKIP_CLEAN_EN
    assign entryWrite = LineIsDirty;
`else
    logic unusedDirty;
    assign unusedDirty = LineIsDirty;
    assign entryWrite  = 1'b1;
`endif

    assign alignedBase = ADDRBITWIDTH'(alignLineBase(64'(LineBase), $clog2(LINESIZE)));

    assign inSpill   = (state == SPILL);
    assign inFill    = (state == FILL);
    assign handshake = clk_en && MemReqValid && MemReqReady;
    assign issueFire = handshake && inFill;
    // A written entry waits for its handshake; a skipped one moves on at once.
    assign spillAdvance = clk_en && inSpill && (entryWrite ? MemReqReady : 1'b1);

    assign ReqReady  = (state == IDLE);
    assign Busy      = (state != IDLE);
    assign DonePulse = (state == DONE);

    assign LineReadEn   = inSpill;
    assign LineReadAddr = inSpill ? spillIdx : '0;
    assign LineCleanEn  = handshake && inSpill;

    assign LineWriteEn   = respFire;
    assign LineWriteAddr = respFire ? respIdx : '0;
    assign LineDataIn    = respFire ? MemRespData : '0;

    assign MemReqValid = (inSpill && entryWrite) || (inFill && !issueDone);
    assign MemReqWrite = inSpill && entryWrite;
    assign MemReqData  = inSpill ? LineDataOut : '0;
    assign MemReqAddr  = inSpill ? (baseReg | ADDRBITWIDTH'(spillIdx)) :
                         inFill  ? (baseReg | ADDRBITWIDTH'(issueIdx)) : '0;

    stack_cache_fill_tracker #(
        .LINESIZE         (LINESIZE),
        .LINEADDRBITWIDTH (LINEADDRBITWIDTH)
    ) fillTracker (
        .clk         (clk),
        .async_rst   (async_rst),
        .clk_en      (clk_en),
        .active      (inFill),
        .issueFire   (issueFire),
        .respValid   (MemRespValid),
        .issueIdx    (issueIdx),
        .respIdx     (respIdx),
        .issueDone   (issueDone),
        .allReturned (allReturned),
        .respFire    (respFire)
    );

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state       <= IDLE;
            spillIdx    <= '0;
            fillPending <= 1'b0;
            baseReg     <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (SpillReq) begin
                        baseReg     <= alignedBase;
                        fillPending <= FillReq;
                        spillIdx    <= '0;
                        state       <= SPILL;
                    end else if (FillReq) begin
                        baseReg     <= alignedBase;
                        fillPending <= 1'b0;
                        state       <= FILL;
                    end
                end
                SPILL: begin
                    if (spillAdvance) begin
                        if (spillIdx == LINEADDRBITWIDTH'(LINESIZE - 1)) begin
                            spillIdx    <= '0;
                            fillPending <= 1'b0;
                            state       <= fillPending ? FILL : DONE;
                        end else begin
                            spillIdx <= spillIdx + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (allReturned) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cache_line_xfer_ctrl.sv
// Randomized bench for stack_cache_line_xfer_ctrl against a transaction-level
// model: expected spill writes, fill reads and line writes are derived from
// the line contents, dirty mask and base address of each operation.
module tb_stack_cache_line_xfer_ctrl;
    localparam int LS  = 8;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int LAW = 3;
`ifdef STACK_CACHE_SPILL_SKIP_CLEAN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           async_rst, clk_en, ReqReady, SpillReq, FillReq, Busy, DonePulse;
    logic [AW-1:0]  LineBase, MemReqAddr;
    logic [LAW-1:0] LineReadAddr, LineWriteAddr;
    logic           LineReadEn, LineIsDirty, LineCleanEn, LineWriteEn;
    logic [DW-1:0]  LineDataOut, LineDataIn, MemReqData, MemRespData;
    logic           MemReqValid, MemReqReady, MemReqWrite, MemRespValid;

    always #5 clk = ~clk;

    stack_cache_line_xfer_ctrl #(.LINESIZE(LS), .DATABITWIDTH(DW), .ADDRBITWIDTH(AW)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .ReqReady(ReqReady),
        .SpillReq(SpillReq), .FillReq(FillReq), .LineBase(LineBase), .Busy(Busy),
        .DonePulse(DonePulse), .LineReadAddr(LineReadAddr), .LineReadEn(LineReadEn),
        .LineDataOut(LineDataOut), .LineIsDirty(LineIsDirty), .LineCleanEn(LineCleanEn),
        .LineWriteAddr(LineWriteAddr), .LineWriteEn(LineWriteEn), .LineDataIn(LineDataIn),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqWrite(MemReqWrite),
        .MemReqAddr(MemReqAddr), .MemReqData(MemReqData), .MemRespValid(MemRespValid),
        .MemRespData(MemRespData)
    );

    // line array stand-in
    logic [DW-1:0] lineData [LS];
    logic [LS-1:0] lineDirty;
    assign LineDataOut = lineData[LineReadAddr];
    assign LineIsDirty = lineDirty[LineReadAddr];

    int checks = 0, failures = 0;
    int cycle = 0, enCycle = 0;
    int readyPct = 100, enPct = 100, latency = 1;
    int forceReadyLow = 0, forceEnLow = 0, freezeAt = -1;
    bit forceEnHigh = 1'b0, reqNoise = 1'b0;
    int wrAddr[$], wrData[$], rdAddr[$], lwAddr[$], lwData[$];
    int pendData[$], pendDue[$];
    int cleanCnt, doneCnt, doneCycle, respSeed, respIdx;
    // current operation
    bit            opSp, opFl;
    int            opAb, opSeed, t0;
    logic [LS-1:0] opDirty;
    logic [DW-1:0] snap [LS];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs just after posedge, observe at negedge.
    task automatic tick();
        bit en;
        if (cycle == freezeAt) forceEnLow = 3;
        en = (forceEnLow > 0) ? 1'b0 : (forceEnHigh ? 1'b1 : (int'($urandom_range(99)) < enPct));
        if (forceEnLow > 0) forceEnLow--;
        clk_en = en;
        MemReqReady = (forceReadyLow > 0) ? 1'b0 : (int'($urandom_range(99)) < readyPct);
        if (forceReadyLow > 0) forceReadyLow--;
        if (pendDue.size() > 0 && pendDue[0] <= enCycle) begin
            MemRespValid = 1'b1;
            MemRespData  = DW'(pendData[0]);
        end else begin
            MemRespValid = 1'b0;
            MemRespData  = DW'($urandom);
        end
        if (reqNoise) begin
            if (Busy && !DonePulse) begin
                SpillReq = 1'($urandom_range(1));
                FillReq  = 1'($urandom_range(1));
            end else begin
                SpillReq = 1'b0;
                FillReq  = 1'b0;
            end
        end
        @(negedge clk);
        if (en) begin
            if (MemReqValid && MemReqReady) begin
                if (MemReqWrite) begin
                    wrAddr.push_back(int'(MemReqAddr));
                    wrData.push_back(int'(MemReqData));
                end else begin
                    rdAddr.push_back(int'(MemReqAddr));
                    pendData.push_back((respSeed + respIdx) & 16'hFFFF);
                    pendDue.push_back(enCycle + latency);
                    respIdx++;
                end
            end
            if (MemRespValid) begin
                void'(pendData.pop_front());
                void'(pendDue.pop_front());
            end
            if (LineWriteEn) begin
                lwAddr.push_back(int'(LineWriteAddr));
                lwData.push_back(int'(LineDataIn));
                lineData[LineWriteAddr] = LineDataIn;
            end
            if (LineCleanEn) begin
                cleanCnt++;
                lineDirty[LineReadAddr] = 1'b0;
            end
            if (DonePulse) begin
                doneCnt++;
                doneCycle = cycle;
            end
            enCycle++;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic startOp(input bit sp, input bit fl, input logic [AW-1:0] base,
                           input logic [LS-1:0] dirty, input int seed);
        opSp = sp; opFl = fl; opDirty = dirty; opSeed = seed;
        opAb = (int'(base) / LS) * LS;
        for (int i = 0; i < LS; i++) begin
            lineData[i] = DW'($urandom);
            snap[i]     = lineData[i];
        end
        lineDirty = dirty;
        wrAddr.delete(); wrData.delete(); rdAddr.delete(); lwAddr.delete(); lwData.delete();
        cleanCnt = 0; doneCnt = 0; doneCycle = 0; respSeed = seed; respIdx = 0;
        reqNoise = 1'b0;
        SpillReq = sp; FillReq = fl; LineBase = base;
        forceEnHigh = 1'b1;
        t0 = cycle;
        tick();
        forceEnHigh = 1'b0;
        SpillReq = 1'b0; FillReq = 1'b0;
        chk("accept_busy", 32'(Busy), 1);
    endtask

    task automatic finishOp(output int lat);
        int k;
        reqNoise = 1'b1;
        for (int n = 0; n < 400 && doneCnt == 0; n++) tick();
        reqNoise = 1'b0;
        SpillReq = 1'b0; FillReq = 1'b0;
        chk("done_once", doneCnt, 1);
        chk("idle_after", 32'(ReqReady), 1);
        lat = doneCycle - t0;
        k = 0;
        if (opSp) begin
            for (int i = 0; i < LS; i++) begin
                if (!SKIP || opDirty[i]) begin
                    if (k < wrAddr.size()) begin
                        chk("spill_addr", wrAddr[k], opAb + i);
                        chk("spill_data", wrData[k], 32'(snap[i]));
                    end
                    k++;
                end
            end
        end
        chk("spill_cnt", wrAddr.size(), k);
        chk("clean_cnt", cleanCnt, k);
        chk("dirty_left", 32'(lineDirty), opSp ? 32'd0 : 32'(opDirty));
        if (opFl) begin
            for (int j = 0; j < LS; j++) begin
                if (j < rdAddr.size()) chk("fill_addr", rdAddr[j], opAb + j);
                if (j < lwAddr.size()) begin
                    chk("fill_idx", lwAddr[j], j);
                    chk("fill_data", lwData[j], (opSeed + j) & 16'hFFFF);
                end
            end
        end
        chk("fill_reads", rdAddr.size(), opFl ? LS : 0);
        chk("fill_writes", lwAddr.size(), opFl ? LS : 0);
    endtask

    initial begin
        int lat0, lat1;
        async_rst = 1'b1; clk_en = 1'b0; SpillReq = 1'b0; FillReq = 1'b0; LineBase = '0;
        MemReqReady = 1'b0; MemRespValid = 1'b0; MemRespData = '0; lineDirty = '0;
        for (int i = 0; i < LS; i++) lineData[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        async_rst = 1'b0;
        chk("rst_ReqReady", 32'(ReqReady), 1);
        chk("rst_Busy", 32'(Busy), 0);
        chk("rst_Done", 32'(DonePulse), 0);
        chk("rst_MemReqValid", 32'(MemReqValid), 0);
        chk("rst_MemReqAddr", 32'(MemReqAddr), 0);
        chk("rst_LineReadEn", 32'(LineReadEn), 0);
        chk("rst_LineWriteEn", 32'(LineWriteEn), 0);
        chk("rst_LineCleanEn", 32'(LineCleanEn), 0);

        // dirty {1,5}, memory always ready: done 9 cycles after accept
        startOp(1'b1, 1'b0, 16'h1234, 8'b0010_0010, 0);
        finishOp(lat0);
        chk("spill_done_cycle", lat0, LS + 1);

        // spill + fill, all clean, response latency 3, data 0xA0..0xA7
        latency = 3;
        startOp(1'b1, 1'b1, 16'h4F0A, 8'h00, 16'hA0);
        finishOp(lat0);

        // all-clean spill alone
        latency = 1;
        startOp(1'b1, 1'b0, 16'h0808, 8'h00, 0);
        finishOp(lat0);

        // memory stalls 4 cycles on the first dirty entry
        startOp(1'b1, 1'b0, 16'h2227, 8'hFF, 0);
        forceReadyLow = 4;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("stall_valid", 32'(MemReqValid), 1);
            chk("stall_addr", 32'(MemReqAddr), opAb);
            chk("stall_data", 32'(MemReqData), 32'(snap[0]));
            chk("stall_idx", 32'(LineReadAddr), 0);
        end
        chk("stall_no_clean", cleanCnt, 0);
        finishOp(lat0);
        chk("stall_done_cycle", lat0, LS + 1 + 4);

        // clk_en freeze mid-fill delays completion by exactly the freeze
        latency = 2;
        startOp(1'b0, 1'b1, 16'h7770, 8'h00, 16'h300);
        finishOp(lat0);
        freezeAt = cycle + 5;
        startOp(1'b0, 1'b1, 16'h7770, 8'h00, 16'h300);
        finishOp(lat1);
        freezeAt = -1;
        chk("freeze_delay", lat1, lat0 + 3);

        // reset after 3 fill responses; remaining responses must be ignored
        latency = 3;
        startOp(1'b0, 1'b1, 16'h5550, 8'h00, 16'h900);
        for (int n = 0; n < 100 && lwAddr.size() < 3; n++) tick();
        chk("rst_mid_writes", lwAddr.size(), 3);
        #2;
        async_rst = 1'b1;
        #1;
        chk("rst_mid_ReqReady", 32'(ReqReady), 1);
        chk("rst_mid_Busy", 32'(Busy), 0);
        tick();
        async_rst = 1'b0;
        repeat (8) tick();
        chk("rst_late_resp_ignored", lwAddr.size(), 3);
        chk("rst_no_req", 32'(MemReqValid), 0);
        pendData.delete(); pendDue.delete();

        // randomized operations with stalls, clk_en gaps and request noise
        for (int r = 0; r < 20; r++) begin
            bit sp, fl;
            sp = 1'($urandom_range(1));
            fl = sp ? 1'($urandom_range(1)) : 1'b1;
            latency  = int'($urandom_range(1, 4));
            readyPct = int'($urandom_range(40, 100));
            enPct    = int'($urandom_range(60, 100));
            startOp(sp, fl, AW'($urandom), LS'($urandom), int'($urandom_range(16'hFFFF)));
            finishOp(lat0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
